// File: rtl/v_cpu_pkg.sv
// Shared definitions for the CPU pipeline: opcode classes, ALU function codes,
// memory opcodes, execute-stage FSM encoding and divide-by-zero results.
package v_cpu_pkg;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_JMP = 2'b10;
    localparam logic [1:0] CLS_RSV = 2'b11;

    localparam logic [3:0] FN_ADD  = 4'h0;
    localparam logic [3:0] FN_SUB  = 4'h1;
    localparam logic [3:0] FN_AND  = 4'h2;
    localparam logic [3:0] FN_OR   = 4'h3;
    localparam logic [3:0] FN_XOR  = 4'h4;
    localparam logic [3:0] FN_SLT  = 4'h5;
    localparam logic [3:0] FN_SLL  = 4'h6;
    localparam logic [3:0] FN_SRL  = 4'h7;
    localparam logic [3:0] FN_MUL  = 4'h8;
    localparam logic [3:0] FN_DIVU = 4'h9;
    localparam logic [3:0] FN_REMU = 4'hA;

    localparam logic [5:0] OP_SW = 6'b010000;
    localparam logic [5:0] OP_LW = 6'b010001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_mode_t;

    // Quotient on divide-by-zero is all-ones (sliced to the datapath width);
    // the remainder is the dividend itself.
    localparam logic [63:0] DIVZ_QUOT = '1;

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op[5:4] == CLS_ALU) &&
               (op[3:0] == FN_MUL || op[3:0] == FN_DIVU || op[3:0] == FN_REMU);
    endfunction

    function automatic md_mode_t md_mode_of(input logic [3:0] fn);
        md_mode_t m;
        case (fn)
            FN_DIVU: m = MD_DIVU;
            FN_REMU: m = MD_REMU;
            default: m = MD_MUL;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/v_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per step.
// result_o is the value after the current step, valid when done_o is high.
module v_muldiv
    import v_cpu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  md_mode_t     mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         step_i,
    input  logic         last_i,
    output logic [W-1:0] result_o,
    output logic         done_o
);

    md_mode_t       mode_q, mode_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [2*W-1:0] sr_q, sr_d;

    logic [W:0]     mul_sum;
    logic [W:0]     rem_shift;
    logic [W:0]     rem_diff;
    logic           rem_ge;
    logic [W-1:0]   rem_new;

    always_comb begin
        // Multiply: sr = {partial high, remaining multiplier bits}, acc = multiplicand.
        mul_sum   = {1'b0, sr_q[2*W-1:W]} + (sr_q[0] ? {1'b0, acc_q} : '0);
        // Divide: sr = {remainder, dividend/quotient}, acc = divisor.
        rem_shift = sr_q[2*W-1:W-1];
        rem_diff  = rem_shift - {1'b0, acc_q};
        rem_ge    = (rem_shift >= {1'b0, acc_q});
        rem_new   = rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
    end

    always_comb begin
        mode_d = mode_q;
        acc_d  = acc_q;
        sr_d   = sr_q;
        if (start_i) begin
            mode_d = mode_i;
            if (mode_i == MD_MUL) begin
                acc_d = a_i;
                sr_d  = {{W{1'b0}}, b_i};
            end else begin
                acc_d = b_i;
                sr_d  = {{W{1'b0}}, a_i};
            end
        end else if (step_i) begin
            if (mode_q == MD_MUL) begin
                sr_d = {mul_sum, sr_q[W-1:1]};
            end else begin
                sr_d = {rem_new, sr_q[W-2:0], rem_ge};
            end
        end
    end

    always_comb begin
        result_o = sr_d[W-1:0];
        case (mode_q)
            MD_DIVU: result_o = (acc_q == '0) ? DIVZ_QUOT[W-1:0] : sr_d[W-1:0];
            MD_REMU: result_o = sr_d[2*W-1:W];
            default: result_o = sr_d[W-1:0];
        endcase
        done_o = step_i & last_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MD_MUL;
            acc_q  <= '0;
            sr_q   <= '0;
        end else begin
            mode_q <= mode_d;
            acc_q  <= acc_d;
            sr_q   <= sr_d;
        end
    end

endmodule

// File: rtl/v_execute.sv
// Execute stage: single-cycle ALU / address generation registered at transfer,
// MUL/DIVU/REMU handed to the iterative unit while in_ready is held low.
module v_execute
    import v_cpu_pkg::*;
#(
    parameter int W     = 32,
    parameter int STEPS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [5:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [15:0]  imm_i,
    input  logic [W-1:0] pc_i,
    output logic         out_valid,
    output logic [5:0]   op_o,
    output logic [W-1:0] alu_o,
    output logic [W-1:0] addr_o
);

    localparam int CW = $clog2(STEPS);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [5:0]     lat_op_q, lat_op_d;
    logic           out_valid_q, out_valid_d;
    logic [5:0]     op_q, op_d;
    logic [W-1:0]   alu_q, alu_d;
    logic [W-1:0]   addr_q, addr_d;

    logic           xfer;
    logic [W-1:0]   alu_res;
    logic [W-1:0]   addr_res;
    logic [W-1:0]   imm_sext;
    logic [W-1:0]   fn_res;
    logic           md_start;
    logic           md_step;
    logic           md_last;
    logic           md_done;
    logic [W-1:0]   md_result;

    assign in_ready = (state_q == ST_IDLE);
    assign xfer     = in_valid && in_ready;
    assign imm_sext = {{(W-16){imm_i[15]}}, imm_i};
    assign md_last  = (cnt_q == CW'(STEPS-1));

    always_comb begin
        fn_res = '0;
        case (op_i[3:0])
            FN_ADD: fn_res = a_i + b_i;
            FN_SUB: fn_res = a_i - b_i;
            FN_AND: fn_res = a_i & b_i;
            FN_OR:  fn_res = a_i | b_i;
            FN_XOR: fn_res = a_i ^ b_i;
            FN_SLT: fn_res = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            FN_SLL: fn_res = a_i << b_i[4:0];
            FN_SRL: fn_res = a_i >> b_i[4:0];
            default: fn_res = '0;
        endcase
    end

    always_comb begin
        alu_res  = '0;
        addr_res = '0;
        case (op_i[5:4])
            CLS_ALU: alu_res = fn_res;
            CLS_MEM: begin
                alu_res  = b_i;
                addr_res = a_i + imm_sext;
            end
            CLS_JMP: addr_res = pc_i + 1'b1;
            default: ;
        endcase
    end

    v_muldiv #(.W(W)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .mode_i   (md_mode_of(op_i[3:0])),
        .a_i      (a_i),
        .b_i      (b_i),
        .step_i   (md_step),
        .last_i   (md_last),
        .result_o (md_result),
        .done_o   (md_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_op_d    = lat_op_q;
        out_valid_d = 1'b0;
        op_d        = op_q;
        alu_d       = alu_q;
        addr_d      = addr_q;
        md_start    = 1'b0;
        md_step     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (is_muldiv(op_i)) begin
                        state_d  = ST_BUSY;
                        cnt_d    = '0;
                        lat_op_d = op_i;
                        md_start = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        op_d        = op_i;
                        alu_d       = alu_res;
                        addr_d      = addr_res;
                    end
                end
            end
            ST_BUSY: begin
                md_step = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (md_done) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    op_d        = lat_op_q;
                    alu_d       = md_result;
                    addr_d      = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_op_q    <= '0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            alu_q       <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_op_q    <= lat_op_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            alu_q       <= alu_d;
            addr_q      <= addr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op_o      = op_q;
    assign alu_o     = alu_q;
    assign addr_o    = addr_q;

endmodule

// File: tb/tb_v_execute.sv
// Directed bench for v_execute: inputs driven and outputs sampled on falling edges.
module tb_v_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op_i;
    logic [31:0] a_i, b_i, pc_i;
    logic [15:0] imm_i;
    logic        out_valid;
    logic [5:0]  op_o;
    logic [31:0] alu_o, addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    v_execute #(.W(32), .STEPS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .imm_i     (imm_i),
        .pc_i      (pc_i),
        .out_valid (out_valid),
        .op_o      (op_o),
        .alu_o     (alu_o),
        .addr_o    (addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present one instruction for a single rising edge, return at the next falling edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [31:0] pc);
        op_i = op; a_i = a; b_i = b; imm_i = imm; pc_i = pc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Multi-cycle op: measure latency (cycles from transfer) and cycles with in_ready low.
    task automatic run_mc(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat;
        int busy;
        issue(op, a, b, 16'h0, 32'h0);
        a_i = 32'h5A5A_5A5A;
        b_i = 32'h0000_0003;
        lat = 1;
        busy = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 33);
        chk({tag, "_busy"}, busy, 32);
        chk({tag, "_rdy"}, {31'b0, in_ready}, 1);
        chk({tag, "_alu"}, alu_o, exp);
        chk({tag, "_op"}, {26'b0, op_o}, {26'b0, op});
        @(negedge clk);
        chk({tag, "_vlo"}, {31'b0, out_valid}, 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; in_valid = 1'b0;
        op_i = '0; a_i = '0; b_i = '0; imm_i = '0; pc_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_alu", alu_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_op", {26'b0, op_o}, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_ready", {31'b0, in_ready}, 1);

        issue(6'b000000, 32'd7, 32'hFFFF_FFFF, 16'h0, 32'h0);
        chk("add_valid", {31'b0, out_valid}, 1);
        chk("add_alu", alu_o, 32'd6);
        chk("add_addr", addr_o, 0);
        @(negedge clk);
        chk("add_vlo", {31'b0, out_valid}, 0);
        chk("add_hold", alu_o, 32'd6);

        issue(6'b010000, 32'h10, 32'hDEAD, 16'hFFFC, 32'h0);
        chk("sw_addr", addr_o, 32'h0C);
        chk("sw_alu", alu_o, 32'hDEAD);
        chk("sw_op", {26'b0, op_o}, 32'h10);
        issue(6'b100000, 32'h1234, 32'h5678, 16'h0, 32'h40);
        chk("jal_addr", addr_o, 32'h41);
        chk("jal_alu", alu_o, 0);
        issue(6'b110101, 32'h1234, 32'h5678, 16'h7, 32'h40);
        chk("rsv_valid", {31'b0, out_valid}, 1);
        chk("rsv_alu", alu_o, 0);
        chk("rsv_addr", addr_o, 0);
        issue(6'b000001, 32'd3, 32'd5, 16'h0, 32'h0);
        chk("sub_alu", alu_o, 32'hFFFF_FFFE);
        issue(6'b000111, 32'h8000_0000, 32'h24, 16'h0, 32'h0);
        chk("srl_alu", alu_o, 32'h0800_0000);
        issue(6'b000110, 32'h3, 32'h1F, 16'h0, 32'h0);
        chk("sll_alu", alu_o, 32'h8000_0000);

        run_mc("mul_big", 6'b001000, 32'h10000, 32'h10000, 32'h0);
        run_mc("mul", 6'b001000, 32'd123, 32'd456, 32'd56088);
        run_mc("divu", 6'b001001, 32'd100, 32'd7, 32'd14);
        run_mc("remu", 6'b001010, 32'd100, 32'd7, 32'd2);
        run_mc("divu0", 6'b001001, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_mc("remu0", 6'b001010, 32'd5, 32'd0, 32'd5);

        issue(6'b001001, 32'd100, 32'd7, 16'h0, 32'h0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", {31'b0, in_ready}, 1);
        chk("abort_valid", {31'b0, out_valid}, 0);
        chk("abort_alu", alu_o, 0);
        chk("abort_op", {26'b0, op_o}, 0);
        issue(6'b000000, 32'd2, 32'd3, 16'h0, 32'h0);
        chk("post_valid", {31'b0, out_valid}, 1);
        chk("post_alu", alu_o, 32'd5);
        pulses = 0;
        repeat (35) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort_nopulse", pulses, 0);

        for (int i = 0; i < 10; i++) begin
            op_i = 6'b000000; a_i = 32'(i * 100); b_i = 32'(i); in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", i), {31'b0, out_valid}, 1);
            chk($sformatf("b2b_alu%0d", i), alu_o, 32'(i * 101));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end", {31'b0, out_valid}, 0);

        issue(6'b000101, 32'hFFFF_FFFF, 32'd1, 16'h0, 32'h0);
        chk("slt_neg", alu_o, 32'd1);
        issue(6'b000101, 32'd1, 32'hFFFF_FFFF, 16'h0, 32'h0);
        chk("slt_pos", alu_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
